if_fetch_queue: RTL

Instruction-fetch stage between the PC register and the decode stage. Turns each enabled PC value into a request to instruction memory with a grant handshake, tolerates variable in-order read latency, and buffers {pc, inst} pairs in a DEPTH-entry queue drained by decode via valid/ready. Drives a hold signal back to the PC register so the PC advances only when its request has been accepted. Supports a single-cycle flush for branches and exceptions.

---
 rtl/if_fetch_queue_pkg.sv | 17 +
 rtl/if_fetch_queue_mem.sv | 43 ++++
 rtl/if_fetch_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue slice.
package if_fetch_queue_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam logic        RstEnable  = 1'b1;
    localparam logic        ChipEnable = 1'b1;
    localparam int unsigned IfqDepth   = 4;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
        logic       filled;
    } ifq_entry_t;

endpackage

// File: rtl/if_fetch_queue_mem.sv
// Fetch-queue storage: PC written at allocation, instruction and filled flag
// written at response, combinational read of the head entry.
module fetch_queue_mem
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IfqDepth,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_we,
    input  logic [AW-1:0] alloc_idx,
    input  inst_addr_t    alloc_pc,
    input  logic          fill_we,
    input  logic [AW-1:0] fill_idx,
    input  inst_t         fill_inst,
    input  logic [AW-1:0] rd_idx,
    output ifq_entry_t    rd_entry
);

    ifq_entry_t mem [DEPTH];

    // Only the filled flags need a reset value; pc/inst are qualified by pointers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_we) begin
                mem[alloc_idx].pc     <= alloc_pc;
                mem[alloc_idx].filled <= 1'b0;
            end
            if (fill_we) begin
                mem[fill_idx].inst   <= fill_inst;
                mem[fill_idx].filled <= 1'b1;
            end
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues PC requests to imem under a credit check,
// collects in-order responses into a queue drained by decode, supports flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IfqDepth
) (
    input  logic       clk,
    input  logic       rst,
    input  inst_addr_t pc_i,
    input  logic       ce_i,
    output logic       pc_hold_o,
    output logic       imem_req_o,
    output inst_addr_t imem_addr_o,
    input  logic       imem_gnt_i,
    input  logic       imem_rvalid_i,
    input  inst_t      imem_rdata_i,
    input  logic       flush_i,
    output logic       id_valid_o,
    input  logic       id_ready_i,
    output inst_addr_t id_pc_o,
    output inst_t      id_inst_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW:0] DepthW = (PW+1)'(DEPTH);

    logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
    logic [PW-1:0] occupancy, inflight;
    logic          credit_ok, grant, pop;
    logic          rsp_drop, rsp_fill, rsp_used;
    ifq_entry_t    rd_entry;

    assign occupancy = alloc_ptr - rd_ptr;
    assign inflight  = alloc_ptr - fill_ptr;
    assign credit_ok = ({1'b0, occupancy} + {1'b0, drop_cnt}) < DepthW;

    assign imem_req_o  = (ce_i == ChipEnable) && !flush_i && (rst != RstEnable) && credit_ok;
    assign imem_addr_o = pc_i;
    assign grant       = imem_req_o && imem_gnt_i;
    assign pc_hold_o   = (ce_i == ChipEnable) && (rst != RstEnable) && !grant;

    // Stale responses are consumed first; anything unmatched is ignored.
    assign rsp_drop = imem_rvalid_i && (drop_cnt != '0);
    assign rsp_fill = imem_rvalid_i && (drop_cnt == '0) && (inflight != '0);
    assign rsp_used = rsp_drop || rsp_fill;

    assign id_valid_o = (rst != RstEnable) && (rd_ptr != fill_ptr) && rd_entry.filled;
    assign id_pc_o    = id_valid_o ? rd_entry.pc   : '0;
    assign id_inst_o  = id_valid_o ? rd_entry.inst : '0;
    assign pop        = id_valid_o && id_ready_i;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
        end else if (flush_i) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            // Outstanding live requests become stale; this cycle's response is already accounted.
            drop_cnt  <= drop_cnt + inflight - PW'(rsp_used);
        end else begin
            if (grant)    alloc_ptr <= alloc_ptr + 1'b1;
            if (rsp_fill) fill_ptr  <= fill_ptr + 1'b1;
            if (pop)      rd_ptr    <= rd_ptr + 1'b1;
            if (rsp_drop) drop_cnt  <= drop_cnt - 1'b1;
        end
    end

    fetch_queue_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .alloc_we  (grant),
        .alloc_idx (alloc_ptr[AW-1:0]),
        .alloc_pc  (pc_i),
        .fill_we   (rsp_fill),
        .fill_idx  (fill_ptr[AW-1:0]),
        .fill_inst (imem_rdata_i),
        .rd_idx    (rd_ptr[AW-1:0]),
        .rd_entry  (rd_entry)
    );

endmodule
